cmp_flag_unit: RTL and testbench
================================

CMP_FLAG_UNIT -- requirements
Module: cmp_flag_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand and result width.
REQ-002 SHALL have parameter CHUNK_W, default 8: bits processed per cycle; DATA_W % CHUNK_W == 0 is required, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: unit can accept operands.
REQ-007 SHALL have ports op_a and op_b, inputs, DATA_W bits each: minuend and subtrahend.
REQ-008 SHALL have port out_valid, output, 1 bit: result and flags available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port diff, output, DATA_W bits: op_a - op_b, modulo 2^DATA_W.
REQ-011 SHALL have ports Z, N, V, C, outputs, 1 bit each: zero, negative, signed-overflow and carry flags.

Function
REQ-012 SHALL compute op_a + ~op_b + 1, one CHUNK_W slice per cycle, LSB slice first, carry-in of slice 0 = 1, carry between slices registered.
REQ-013 SHALL set C = carry out of the MSB slice: 1 means no borrow (op_a >= op_b unsigned).
REQ-014 SHALL set Z = (diff == 0) and N = diff[DATA_W-1].
REQ-015 SHALL set V = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]).
REQ-016 SHALL implement an FSM with states IDLE, CALC and DONE.
  - IDLE: in_ready = 1; on in_valid, latch op_a/op_b, clear slice count, go to CALC.
  - CALC: in_ready = 0; one slice per cycle; after slice NS-1 (NS = DATA_W/CHUNK_W), go to DONE.
  - DONE: out_valid = 1; on out_ready, go to IDLE.
REQ-017 Latency: with acceptance on edge k, out_valid SHALL be first high in the cycle after edge k+NS (default: 4 cycles after acceptance).
REQ-018 diff, Z, N, V and C SHALL be stable while out_valid=1 and out_ready=0, for an unbounded stall.
REQ-019 in_ready SHALL be 0 in CALC and DONE; inputs changing then SHALL have no effect.
REQ-020 After an output handshake, in_ready SHALL be 1 in the next cycle; no overlap of consecutive operations.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 Flag outputs SHALL be consistent with the consumer's branch encoding: BEQ=Z, BNE=~Z, BLT/SLT=N^V, BGE=~(N^V), BLTU/SLTU=~C, BGEU=C.

Reset
REQ-023 rst=1 SHALL force IDLE, in_ready=1 (in the cycle after the reset edge), out_valid=0, diff=0, Z=0, N=0, V=0, C=0, slice count=0, and inter-slice carry=0.
REQ-024 rst asserted during CALC or DONE SHALL abort the operation with no result handshake; rst takes priority over every other event in the same cycle.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE/CALC/DONE) and the defaults for DATA_W and CHUNK_W.
REQ-026 SHALL instantiate one combinational sub-module, sub_chunk (CHUNK_W-bit a + ~b + cin, producing sum and cout), reused each cycle.
REQ-027 Slice results SHALL be written into a DATA_W-bit result register by slice index; flags SHALL be registered on entry to DONE.

Verification
REQ-028 SHALL cover: 0x00000005 - 0x00000005 -> diff=0, Z=1, N=0, V=0, C=1, out_valid 4 cycles after acceptance.
REQ-029 SHALL cover: 0x00000003 - 0x00000005 -> diff=0xFFFFFFFE, Z=0, N=1, V=0, C=0.
REQ-030 SHALL cover: 0x80000000 - 0x00000001 -> diff=0x7FFFFFFF, N=0, V=1, C=1; and 0x00000000 - 0xFFFFFFFF -> diff=0x00000001, C=0, V=0.
REQ-031 SHALL cover inter-slice borrow: 0x00000100 - 0x00000001 -> diff=0x000000FF, C=1, Z=0.
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles -> outputs constant, in_ready=0; then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 next cycle.
REQ-033 SHALL cover reset mid-CALC: rst on cycle 2 after acceptance -> out_valid never asserts, in_ready=1 after reset, and the next operation completes correctly.

Source files
------------

// File: rtl/cmp_flag_unit_pkg.sv
// rtl/cmp_flag_unit_pkg.sv - shared state encoding and width defaults for the compare/flag unit
package cmp_flag_unit_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int CHUNK_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/cmp_flag_unit_sub_chunk.sv
// rtl/cmp_flag_unit_sub_chunk.sv - one slice of a + ~b + cin, reused every cycle
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry out of the slice falls out of the add
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/cmp_flag_unit.sv
// rtl/cmp_flag_unit.sv - multi-cycle subtractor producing Z/N/V/C branch flags
module cmp_flag_unit
  import cmp_flag_unit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              Z,
  output logic              N,
  output logic              V,
  output logic              C
);

  localparam int NS    = DATA_W / CHUNK_W;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

  generate
    if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
      $error("cmp_flag_unit: DATA_W must be a multiple of CHUNK_W");
    end
  endgenerate

  cmp_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, res_q, res_next;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic              last_slice;
  logic [CHUNK_W-1:0] a_sl, b_sl, sum_sl;
  logic              cout_sl;
  int                base;

  assign base       = int'(idx_q) * CHUNK_W;
  assign last_slice = (idx_q == IDX_W'(NS - 1));
  assign a_sl       = a_q[base +: CHUNK_W];
  assign b_sl       = b_q[base +: CHUNK_W];

  sub_chunk #(.W(CHUNK_W)) u_sub_chunk (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (cout_sl)
  );

  // Result with the current slice merged in, so flags can be taken on the final slice cycle
  always_comb begin
    res_next = res_q;
    res_next[base +: CHUNK_W] = sum_sl;
  end

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (last_slice) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, slice accumulation and flag registration on the way into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
      C       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            idx_q   <= '0;
            carry_q <= 1'b1;
          end
        end
        ST_CALC: begin
          res_q   <= res_next;
          carry_q <= cout_sl;
          idx_q   <= idx_q + 1'b1;
          if (last_slice) begin
            Z <= (res_next == '0);
            N <= res_next[DATA_W-1];
            V <= (a_q[DATA_W-1] != b_q[DATA_W-1]) && (res_next[DATA_W-1] != a_q[DATA_W-1]);
            C <= cout_sl;
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = res_q;

endmodule

// File: tb/tb_cmp_flag_unit.sv
// tb/tb_cmp_flag_unit.sv - directed self-checking bench for cmp_flag_unit
module tb_cmp_flag_unit;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        Z, N, V, C;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cmp_flag_unit #(.DATA_W(32), .CHUNK_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .Z         (Z),
    .N         (N),
    .V         (V),
    .C         (C)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                        input logic ez, input logic en, input logic ev, input logic ec,
                        input int stall, input logic busy_ready);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    step();
    in_valid  = 1'b0;
    op_a      = ~a;
    op_b      = b ^ 32'h5A5A_5A5A;
    out_ready = busy_ready;
    for (int j = 1; j <= NS; j++) begin
      step();
      chk("out_valid_latency", {31'd0, out_valid}, (j == NS) ? 32'd1 : 32'd0);
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b0;
    chk("diff", diff, ed);
    chk("flags_znvc", {28'd0, Z, N, V, C}, {28'd0, ez, en, ev, ec});
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_diff", diff, ed);
      chk("stall_flags", {28'd0, Z, N, V, C}, {28'd0, ez, en, ev, ec});
      chk("stall_valid_ready", {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_handshake", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'hDEAD_BEEF;
    op_b      = 32'h1234_5678;
    step();
    step();
    chk("rst_ready_valid", {30'd0, out_valid, in_ready}, 32'b01);
    chk("rst_diff", diff, 32'd0);
    chk("rst_flags", {28'd0, Z, N, V, C}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_valid", {31'd0, out_valid}, 32'd0);

    // equal operands
    run_op(32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    // negative result, borrow; stray out_ready during CALC must be ignored
    run_op(32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    // signed overflow without borrow
    run_op(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    // 0 - (-1): borrow, no overflow
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // borrow ripples across the slice boundary
    run_op(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    // max positive minus -1: overflow to negative, borrow
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    // ten-cycle backpressure
    run_op(32'h1234_5678, 32'h1234_5600, 32'h0000_0078, 1'b0, 1'b0, 1'b0, 1'b1, 10, 1'b0);

    // reset two cycles into CALC aborts the operation
    op_a     = 32'h0000_0009;
    op_b     = 32'h0000_0002;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    step();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("abort_ready_valid", {30'd0, out_valid, in_ready}, 32'b01);
    chk("abort_diff", diff, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(32'h0000_0009, 32'h0000_0002, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
